cache_ctrl_fsm: RTL and testbench

- CPU-side controller sitting directly upstream of cache_memory (4-way, 8-bit data, 2-bit age per way).
- Accepts one CPU load/store at a time over a valid/ready handshake and drives the lookup strobes into cache_memory.
- On a read miss, fetches the byte from main memory and installs it in the LRU victim way.
- Write-through, no-write-allocate; every store also goes to main memory.

---
 rtl/cache_ctrl_fsm_if.sv | 53 +++++
 rtl/cache_ctrl_fsm.sv | 154 +++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_fsm_if.sv
// CPU, cache and main-memory signal bundle for cache_ctrl_fsm.
// master = controller view, slave = environment (CPU, cache_memory, memory) view.
interface cache_ctrl_fsm_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned AGE_W  = 2
) ();
  // CPU side
  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic                  cpu_we;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic                  cpu_resp_valid;
  logic [DATA_W-1:0]     cpu_rdata;
  // cache_memory side
  logic [ADDR_W-1:0]     address_word;
  logic                  try_read;
  logic                  try_write;
  logic [DATA_W-1:0]     write_data;
  logic [DATA_W-1:0]     data;
  logic                  hit_miss;
  logic [WAYS-1:0]       hit_miss_set;
  logic [WAYS*AGE_W-1:0] ages;
  logic                  fill;
  logic [WAYS-1:0]       fill_way;
  // main-memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
    input  data, hit_miss, hit_miss_set, ages,
    input  mem_ack, mem_rdata,
    output cpu_req_ready, cpu_resp_valid, cpu_rdata,
    output address_word, try_read, try_write, write_data, fill, fill_way,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
    output data, hit_miss, hit_miss_set, ages,
    output mem_ack, mem_rdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_rdata,
    input  address_word, try_read, try_write, write_data, fill, fill_way,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// CPU-side controller for a 4-way write-through, no-write-allocate cache.
// One request in flight; read misses fetch from memory and fill the LRU way.
module cache_ctrl_fsm #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned AGE_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  cache_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StLookup, StCheck, StMemRd, StFill, StMemWr, StResp
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              resp_q;
  logic              try_read_q;
  logic              fill_q;
  logic [WAYS-1:0]   fill_way_q;
  logic              mem_req_q;
  logic              mem_we_q;

  logic              hit;
  logic [WAYS-1:0]   victim;
  logic [AGE_W-1:0]  best_age;
  logic [AGE_W-1:0]  cur_age;

  // Any hit-way bit also counts as a hit; multi-bit hit vectors use data as-is.
  assign hit = bus.hit_miss | (|bus.hit_miss_set);

  // Victim: oldest way, lowest index on ties (age 2'b11 is the maximum, so it wins first).
  always_comb begin
    best_age = bus.ages[AGE_W-1:0];
    cur_age  = '0;
    victim   = '0;
    victim[0] = 1'b1;
    for (int unsigned i = 1; i < WAYS; i++) begin
      cur_age = bus.ages[AGE_W*i +: AGE_W];
      if (cur_age > best_age) begin
        best_age  = cur_age;
        victim    = '0;
        victim[i] = 1'b1;
      end
    end
  end

  // Main FSM with registered strobes; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b1;
      resp_q     <= 1'b0;
      try_read_q <= 1'b0;
      fill_q     <= 1'b0;
      fill_way_q <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      resp_q     <= 1'b0;
      try_read_q <= 1'b0;
      fill_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cpu_req_valid) begin
            addr_q     <= bus.cpu_addr;
            we_q       <= bus.cpu_we;
            wdata_q    <= bus.cpu_wdata;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            // Stores probe with a read too; the write itself is issued in CHECK on a hit.
            try_read_q <= 1'b1;
            state_q    <= StLookup;
          end
        end
        StLookup: state_q <= StCheck;
        StCheck: begin
          if (we_q) begin
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
            state_q   <= StMemWr;
          end else if (hit) begin
            rdata_q <= bus.data;
            resp_q  <= 1'b1;
            state_q <= StResp;
          end else begin
            fill_way_q <= victim;
            mem_req_q  <= 1'b1;
            state_q    <= StMemRd;
          end
        end
        StMemRd: begin
          if (bus.mem_ack) begin
            rdata_q   <= bus.mem_rdata;
            mem_req_q <= 1'b0;
            fill_q    <= 1'b1;
            state_q   <= StFill;
          end
        end
        StFill: begin
          resp_q  <= 1'b1;
          state_q <= StResp;
        end
        StMemWr: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            resp_q    <= 1'b1;
            state_q   <= StResp;
          end
        end
        StResp: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_q   <= 1'b1;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  // Output decode; try_write must follow hit_miss within the CHECK cycle.
  always_comb begin
    bus.cpu_req_ready  = ready_q;
    bus.cpu_resp_valid = resp_q;
    bus.cpu_rdata      = rdata_q;
    bus.address_word   = addr_q;
    bus.try_read       = try_read_q;
    bus.try_write      = (state_q == StCheck) && we_q && hit;
    bus.write_data     = fill_q ? rdata_q : wdata_q;
    bus.fill           = fill_q;
    bus.fill_way       = fill_q ? fill_way_q : '0;
    bus.mem_req        = mem_req_q;
    bus.mem_we         = mem_we_q;
    bus.mem_addr       = addr_q;
    bus.mem_wdata      = mem_we_q ? wdata_q : '0;
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm with a stub cache and hand-driven memory.
module tb_cache_ctrl_fsm;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  int resp_cnt, tw_cnt, fill_cnt, memreq_cnt, acc_cnt, excl_cnt;

  cache_ctrl_fsm_if #(.ADDR_W(32), .DATA_W(8), .WAYS(4), .AGE_W(2)) bus ();

  cache_ctrl_fsm #(.ADDR_W(32), .DATA_W(8), .WAYS(4), .AGE_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cpu_resp_valid) resp_cnt <= resp_cnt + 1;
      if (bus.try_write) tw_cnt <= tw_cnt + 1;
      if (bus.fill) fill_cnt <= fill_cnt + 1;
      if (bus.mem_req) memreq_cnt <= memreq_cnt + 1;
      if (bus.cpu_req_valid && bus.cpu_req_ready) acc_cnt <= acc_cnt + 1;
      if (int'(bus.try_read) + int'(bus.try_write) + int'(bus.fill) > 1)
        excl_cnt <= excl_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present a request in IDLE; returns in the LOOKUP cycle.
  task automatic accept(input logic we, input logic [31:0] addr, input logic [7:0] wd);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_we        = we;
    bus.cpu_addr      = addr;
    bus.cpu_wdata     = wd;
    tick();
    bus.cpu_req_valid = 1'b0;
  endtask

  int r0, t0, f0, m0, a0;
  int seen;

  initial begin
    n_total = 0; n_bad = 0;
    resp_cnt = 0; tw_cnt = 0; fill_cnt = 0; memreq_cnt = 0; acc_cnt = 0; excl_cnt = 0;
    rst = 1'b1;
    bus.cpu_req_valid = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.data = '0; bus.hit_miss = 1'b0; bus.hit_miss_set = '0; bus.ages = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    check_eq("rst_ready", bus.cpu_req_ready, 1);
    check_eq("rst_resp", bus.cpu_resp_valid, 0);
    check_eq("rst_memreq", bus.mem_req, 0);
    check_eq("rst_tryrd", bus.try_read, 0);
    check_eq("rst_fill", bus.fill, 0);
    check_eq("rst_rdata", bus.cpu_rdata, 0);
    check_eq("rst_addr", bus.address_word, 0);
    rst = 1'b0;
    tick();

    // Load hit
    bus.hit_miss = 1'b1; bus.hit_miss_set = 4'b0001; bus.data = 8'hA5;
    m0 = memreq_cnt; r0 = resp_cnt;
    accept(1'b0, 32'h0000_0040, 8'h00);
    check_eq("lh_tryrd", bus.try_read, 1);
    check_eq("lh_addr", bus.address_word, 32'h40);
    check_eq("lh_ready", bus.cpu_req_ready, 0);
    tick();
    check_eq("lh_check_resp", bus.cpu_resp_valid, 0);
    check_eq("lh_check_tryrd", bus.try_read, 0);
    tick();
    check_eq("lh_resp", bus.cpu_resp_valid, 1);
    check_eq("lh_rdata", bus.cpu_rdata, 8'hA5);
    tick();
    check_eq("lh_resp_gone", bus.cpu_resp_valid, 0);
    check_eq("lh_ready_back", bus.cpu_req_ready, 1);
    check_eq("lh_no_mem", memreq_cnt - m0, 0);
    check_eq("lh_one_resp", resp_cnt - r0, 1);

    // Load miss, way2 aged 2'b11, ack after 5 MEM_RD cycles
    bus.hit_miss = 1'b0; bus.hit_miss_set = 4'b0000; bus.ages = 8'b00_11_01_10;
    accept(1'b0, 32'h0000_0080, 8'h00);
    tick();
    tick();
    check_eq("lm_memreq", bus.mem_req, 1);
    check_eq("lm_memwe", bus.mem_we, 0);
    check_eq("lm_memaddr", bus.mem_addr, 32'h80);
    repeat (4) tick();
    check_eq("lm_memreq_held", bus.mem_req, 1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h3C;
    tick();
    bus.mem_ack = 1'b0;
    check_eq("lm_fill", bus.fill, 1);
    check_eq("lm_fill_way", bus.fill_way, 4'b0100);
    check_eq("lm_wdata", bus.write_data, 8'h3C);
    check_eq("lm_fill_addr", bus.address_word, 32'h80);
    check_eq("lm_memreq_drop", bus.mem_req, 0);
    tick();
    check_eq("lm_resp", bus.cpu_resp_valid, 1);
    check_eq("lm_rdata", bus.cpu_rdata, 8'h3C);
    check_eq("lm_fill_off", bus.fill, 0);
    tick();

    // Victim tie among age 2 -> way1; ack in the cycle mem_req rises
    bus.ages = 8'b10_01_10_00;
    accept(1'b0, 32'h0000_00C0, 8'h00);
    tick();
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h99;
    tick();
    bus.mem_ack = 1'b0;
    check_eq("tie_fill_way", bus.fill_way, 4'b0010);
    check_eq("tie_wdata", bus.write_data, 8'h99);
    tick();
    check_eq("tie_rdata", bus.cpu_rdata, 8'h99);
    tick();

    // Store hit
    bus.hit_miss = 1'b1; bus.hit_miss_set = 4'b0010;
    t0 = tw_cnt; r0 = resp_cnt; f0 = fill_cnt;
    accept(1'b1, 32'h1234_5678, 8'h7E);
    check_eq("sh_probe", bus.try_read, 1);
    check_eq("sh_lookup_tw", bus.try_write, 0);
    tick();
    check_eq("sh_tw", bus.try_write, 1);
    check_eq("sh_wdata", bus.write_data, 8'h7E);
    check_eq("sh_check_tryrd", bus.try_read, 0);
    tick();
    check_eq("sh_memwe", bus.mem_we, 1);
    check_eq("sh_memwdata", bus.mem_wdata, 8'h7E);
    check_eq("sh_memaddr", bus.mem_addr, 32'h1234_5678);
    check_eq("sh_tw_off", bus.try_write, 0);
    tick(); tick();
    check_eq("sh_memreq_held", bus.mem_req, 1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check_eq("sh_resp", bus.cpu_resp_valid, 1);
    check_eq("sh_rdata", bus.cpu_rdata, 0);
    check_eq("sh_memreq_drop", bus.mem_req, 0);
    tick();
    check_eq("sh_one_resp", resp_cnt - r0, 1);
    check_eq("sh_one_tw", tw_cnt - t0, 1);

    // Store miss
    bus.hit_miss = 1'b0; bus.hit_miss_set = 4'b0000;
    t0 = tw_cnt; r0 = resp_cnt;
    accept(1'b1, 32'h0000_0100, 8'h55);
    tick();
    check_eq("sm_tw", bus.try_write, 0);
    tick();
    check_eq("sm_memwe", bus.mem_we, 1);
    check_eq("sm_memwdata", bus.mem_wdata, 8'h55);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check_eq("sm_resp", bus.cpu_resp_valid, 1);
    tick();
    check_eq("sm_no_tw", tw_cnt - t0, 0);
    check_eq("sm_no_fill", fill_cnt - f0, 0);
    check_eq("sm_one_resp", resp_cnt - r0, 1);

    // Back-to-back loads with valid held high
    bus.hit_miss = 1'b1; bus.hit_miss_set = 4'b0001; bus.data = 8'h11;
    a0 = acc_cnt; r0 = resp_cnt; seen = 0;
    bus.cpu_req_valid = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h200;
    for (int i = 0; i < 40 && seen < 3; i++) begin
      tick();
      if (bus.cpu_resp_valid) begin
        seen++;
        check_eq("b2b_rdata", bus.cpu_rdata, 8'h11);
        check_eq("b2b_ready_busy", bus.cpu_req_ready, 0);
        if (seen == 3) bus.cpu_req_valid = 1'b0;
      end
    end
    check_eq("b2b_resps_seen", seen, 3);
    bus.cpu_req_valid = 1'b0;
    tick(); tick();
    check_eq("b2b_accepts", acc_cnt - a0, 3);
    check_eq("b2b_resps", resp_cnt - r0, 3);

    // Reset mid-MEM_RD
    bus.hit_miss = 1'b0; bus.hit_miss_set = 4'b0000;
    accept(1'b0, 32'h0000_0300, 8'h00);
    tick();
    tick();
    check_eq("rr_memreq_up", bus.mem_req, 1);
    r0 = resp_cnt; f0 = fill_cnt;
    rst = 1'b1;
    #1;
    check_eq("rr_memreq_drop", bus.mem_req, 0);
    check_eq("rr_ready", bus.cpu_req_ready, 1);
    check_eq("rr_resp", bus.cpu_resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEE;
    tick();
    bus.mem_ack = 1'b0;
    check_eq("rr_late_ack_fill", bus.fill, 0);
    check_eq("rr_late_ack_memreq", bus.mem_req, 0);
    tick();
    check_eq("rr_late_ack_resp", resp_cnt - r0, 0);
    check_eq("rr_no_fill", fill_cnt - f0, 0);
    check_eq("rr_rdata", bus.cpu_rdata, 0);
    check_eq("rr_ready_idle", bus.cpu_req_ready, 1);

    check_eq("strobe_exclusive", excl_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
